op_lut_regs_mc: RTL and testbench
=================================

Name: op_lut_regs_mc

Overview:
Register-ring slave for the learning-CAM switch output-port lookup. It decodes UDP register requests addressed to its block and serves read/write access to the MAC LUT through a req/ack handshake. Next-generation version: parametrised source-port count, per-source-port saturating hit/miss counters, ack timeout, and a hardware table-flush command. It sits between the LUT/CAM and the UDP register ring, and passes through every request not addressed to it.

Parameters:
NUM_OUTPUT_QUEUES, 8, width of the LUT output-port bitmap (max 15)
LUT_DEPTH_BITS, 5, LUT address width; table holds 2**LUT_DEPTH_BITS entries
NUM_SRC_PORTS, 4, number of source ports with separate hit/miss counters (1..16)
CNT_WIDTH, 32, counter width (1..32); zero-extended on read
ACK_TIMEOUT, 64, maximum cycles to wait for rd_ack/wr_ack (>=2)
UDP_REG_SRC_WIDTH, 2, ring source-tag width
REG_ADDR_BITS, 6, width of the word-offset field inside the block
BLOCK_TAG, 0, value that the upper address bits must equal to select this block

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
reg_req_in / reg_ack_in / reg_rd_wr_L_in  in  1 each  ring request, ack, read(1)/write(0)
reg_addr_in  in  `UDP_REG_ADDR_WIDTH  ring address
reg_data_in  in  `CPCI_NF2_DATA_WIDTH  ring data
reg_src_in  in  UDP_REG_SRC_WIDTH  ring source tag
reg_*_out  out  same widths  registered ring outputs
rd_addr  out  LUT_DEPTH_BITS  LUT read index
rd_req  out  1  LUT read request
rd_oq  in  NUM_OUTPUT_QUEUES  read port bitmap
rd_wr_protect  in  1  read protect bit
rd_mac  in  48  read MAC
rd_ack  in  1  read ack; stays high until rd_req falls
wr_addr  out  LUT_DEPTH_BITS  LUT write index
wr_req  out  1  LUT write request
wr_oq  out  NUM_OUTPUT_QUEUES  write port bitmap
wr_protect  out  1  write protect bit
wr_mac  out  48  write MAC
wr_ack  in  1  write ack; stays high until wr_req falls
lut_hit / lut_miss  in  1 each  one-cycle lookup result strobes
lut_src_port  in  max(1,log2(NUM_SRC_PORTS))  source port of the lookup, valid with the strobes

Behaviour:
- Reset (reset_n low at a clk edge): all reg_*_out=0, rd_req=wr_req=0, all registers and counters=0, state=IDLE. Reset during a LUT op or flush aborts it immediately; no ring response is issued.
- Register map (word offset): 0 PORTS_MAC_HI {protect[31], zero pad, oq[NUM_OUTPUT_QUEUES+15:16], mac[47:32] in [15:0]}; 1 MAC_LO; 2 WR_ADDR (a write triggers a LUT write); 3 RD_ADDR (a write triggers a LUT read); 4 FLUSH (a write of any value triggers a flush); 5 STATUS, read-only {timeout_cnt[15:8], flushing[1], busy[0]}; 6+2p HITS[p]; 7+2p MISSES[p]. Valid offsets: < 6+2*NUM_SRC_PORTS.
- Block select: reg_req_in=1, addr[REG_ADDR_BITS-1:0]=offset, upper bits==BLOCK_TAG.
- Not selected: all ring inputs are copied to the outputs with 1-cycle latency.
- Selected read: next cycle, req=ack=1, data=register value, or 32'hDEAD_BEEF if the offset is invalid.
- Selected write, invalid offset or STATUS: nothing is written; goes to DONE.
- Selected write to 0, 1, or a counter: value loads that register; goes to DONE.
- Selected write to 2 or 3: target register is loaded; state goes to LUT_WR or LUT_RD.
- States IDLE, LUT_WR, LUT_RD, FLUSH_REQ, FLUSH_REL, DONE.
- LUT_WR / LUT_RD: hold the request high until ack. For LUT_RD, on ack load PORTS_MAC_HI and MAC_LO from rd_* data. Then go to DONE.
- FLUSH_REQ: wr_addr=flush_idx, wr_mac=0, wr_oq=0, wr_protect=0, wr_req=1 until wr_ack. FLUSH_REL: wr_req=0 until wr_ack=0. Then, if flush_idx is the last entry, go to DONE; otherwise increment flush_idx and return to FLUSH_REQ. flush_idx starts at 0.
- Timeout: a per-op counter is reset at each request. If ACK_TIMEOUT cycles pass without ack (or without ack release in FLUSH_REL), the op (or the whole flush) aborts. timeout_cnt increments, saturating at 255. Go to DONE with response data 32'hDEAD_BEEF.
- DONE: for one cycle, req=ack=1 with the held rd_wr_L, addr, src and data (or 32'hDEAD_BEEF after a timeout). Then IDLE.
- Ring inputs are ignored while state != IDLE; the ring has one outstanding request at a time. busy=1 whenever state != IDLE.
- Counters: HITS[lut_src_port] += lut_hit; MISSES[lut_src_port] += lut_miss. Both can count in the same cycle. Saturate at all-ones, no wrap. lut_src_port >= NUM_SRC_PORTS is ignored. A ring write in the same cycle wins over an increment. A read returns the pre-increment value.
- Op-done latency: DONE occurs 1 cycle after ack (rd/wr). Flush takes at least 2 cycles per entry.

Optional Feature:
OP_LUT_CLR_ON_READ_EN: when defined, a selected read of HITS/MISSES returns the current value and resets that counter to the same-cycle increment (0 or 1). When not defined, counters are cleared only by a ring write.

Test Plan:
- Write 0x8003_1234 to offset 0, 0x5678_9ABC to offset 1, 7 to offset 2; wr_ack after 3 cycles -> wr_addr=7, wr_mac=0x1234_5678_9ABC, wr_oq=0x03, wr_protect=1; ring ack 1 cycle after wr_ack.
- Write 4 to offset 3; rd_ack with mac 0xAABB_CCDD_EEFF, oq 0x05, protect 0 -> offset 0 reads 0x0005_AABB, offset 1 reads 0xCCDD_EEFF.
- Write to offset 4, LUT acks every request -> 32 writes to addresses 0..31 with zero data; busy=1 throughout; single ring response at the end.
- Never assert wr_ack -> response data 32'hDEAD_BEEF 64 cycles after wr_req; STATUS reads 0x0000_0100.
- CNT_WIDTH=4, 20 hits on port 2 -> HITS[2] reads 0xF; simultaneous hit+miss on port 1 -> both counters increment; read offset 30 -> 32'hDEAD_BEEF.
- Request with a non-matching tag -> identical ring outputs 1 cycle later; reset_n low mid-flush -> wr_req=0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/op_lut_regs_mc.sv
// Register-ring slave for the learning-CAM output-port LUT: table access, flush, per-port hit/miss counters.
// Optional: OP_LUT_CLR_ON_READ_EN makes HITS/MISSES reads clear the counter.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module op_lut_regs_mc #(
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int LUT_DEPTH_BITS    = 5,
  parameter int NUM_SRC_PORTS     = 4,
  parameter int CNT_WIDTH         = 32,
  parameter int ACK_TIMEOUT       = 64,
  parameter int UDP_REG_SRC_WIDTH = 2,
  parameter int REG_ADDR_BITS     = 6,
  parameter int BLOCK_TAG         = 0,
  localparam int SRC_PW = (NUM_SRC_PORTS > 1) ? $clog2(NUM_SRC_PORTS) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              reg_req_in,
  input  logic                              reg_ack_in,
  input  logic                              reg_rd_wr_L_in,
  input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
  input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in,
  output logic                              reg_req_out,
  output logic                              reg_ack_out,
  output logic                              reg_rd_wr_L_out,
  output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
  output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
  output logic [LUT_DEPTH_BITS-1:0]         rd_addr,
  output logic                              rd_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0]      rd_oq,
  input  logic                              rd_wr_protect,
  input  logic [47:0]                       rd_mac,
  input  logic                              rd_ack,
  output logic [LUT_DEPTH_BITS-1:0]         wr_addr,
  output logic                              wr_req,
  output logic [NUM_OUTPUT_QUEUES-1:0]      wr_oq,
  output logic                              wr_protect,
  output logic [47:0]                       wr_mac,
  input  logic                              wr_ack,
  input  logic                              lut_hit,
  input  logic                              lut_miss,
  input  logic [SRC_PW-1:0]                 lut_src_port
);
  localparam int AW    = `UDP_REG_ADDR_WIDTH;
  localparam int DW    = `CPCI_NF2_DATA_WIDTH;
  localparam int TW    = AW - REG_ADDR_BITS;
  localparam int TMO_W = $clog2(ACK_TIMEOUT);
  localparam int NQ    = NUM_OUTPUT_QUEUES;
  localparam logic [DW-1:0] BAD = DW'(32'hDEAD_BEEF);

  typedef enum logic [2:0] {S_IDLE, S_LUT_WR, S_LUT_RD, S_FLUSH_REQ, S_FLUSH_REL, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic                          out_req_q, out_req_d, out_ack_q, out_ack_d, out_rw_q, out_rw_d;
  logic [AW-1:0]                 out_addr_q, out_addr_d, hold_addr_q, hold_addr_d;
  logic [DW-1:0]                 out_data_q, out_data_d, hold_data_q, hold_data_d;
  logic [UDP_REG_SRC_WIDTH-1:0]  out_src_q, out_src_d, hold_src_q, hold_src_d;
  logic                          hold_rw_q, hold_rw_d;
  logic                          protect_q, protect_d;
  logic [NQ-1:0]                 oq_q, oq_d;
  logic [47:0]                   mac_q, mac_d;
  logic [LUT_DEPTH_BITS-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, flush_idx_q, flush_idx_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic [7:0]                    timeout_cnt_q, timeout_cnt_d;
  logic                          rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [CNT_WIDTH-1:0]          hits_q [NUM_SRC_PORTS];
  logic [CNT_WIDTH-1:0]          hits_d [NUM_SRC_PORTS];
  logic [CNT_WIDTH-1:0]          misses_q [NUM_SRC_PORTS];
  logic [CNT_WIDTH-1:0]          misses_d [NUM_SRC_PORTS];

  logic                          sel, fin, tmo_fail, tmo_end, flushing, busy;
  logic [DW-1:0]                 fin_data, rd_val;
  logic [31:0]                   offi;
  logic [NUM_SRC_PORTS-1:0]      hit_inc, miss_inc;

  assign flushing = (state_q == S_FLUSH_REQ) || (state_q == S_FLUSH_REL);
  assign busy     = (state_q != S_IDLE);
  assign offi     = 32'(reg_addr_in[REG_ADDR_BITS-1:0]);
  assign sel      = reg_req_in && (reg_addr_in[AW-1:REG_ADDR_BITS] == TW'(BLOCK_TAG));
  assign tmo_end  = (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

  // read mux; counters are zero-extended, unknown offsets read as DEAD_BEEF
  always_comb begin
    rd_val = BAD;
    case (offi)
      32'd0: begin
        rd_val = '0;
        rd_val[31] = protect_q;
        rd_val[16 +: NQ] = oq_q;
        rd_val[15:0] = mac_q[47:32];
      end
      32'd1: rd_val = DW'(mac_q[31:0]);
      32'd2: rd_val = DW'(wr_addr_q);
      32'd3: rd_val = DW'(rd_addr_q);
      32'd4: rd_val = '0;
      32'd5: begin
        rd_val = '0;
        rd_val[15:8] = timeout_cnt_q;
        rd_val[1] = flushing;
        rd_val[0] = busy;
      end
      default: ;
    endcase
    for (int p = 0; p < NUM_SRC_PORTS; p++) begin
      if (offi == 32'(6 + 2*p)) rd_val = DW'(hits_q[p]);
      if (offi == 32'(7 + 2*p)) rd_val = DW'(misses_q[p]);
    end
  end

  always_comb begin
    state_d       = state_q;
    out_req_d     = 1'b0;
    out_ack_d     = 1'b0;
    out_rw_d      = 1'b0;
    out_addr_d    = '0;
    out_data_d    = '0;
    out_src_d     = '0;
    hold_rw_d     = hold_rw_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    hold_src_d    = hold_src_q;
    protect_d     = protect_q;
    oq_d          = oq_q;
    mac_d         = mac_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    flush_idx_d   = flush_idx_q;
    tmo_d         = tmo_q;
    timeout_cnt_d = timeout_cnt_q;
    rd_req_d      = rd_req_q;
    wr_req_d      = wr_req_q;
    fin           = 1'b0;
    tmo_fail      = 1'b0;
    fin_data      = hold_data_q;

    for (int p = 0; p < NUM_SRC_PORTS; p++) begin
      hit_inc[p]  = lut_hit  && (32'(lut_src_port) == p);
      miss_inc[p] = lut_miss && (32'(lut_src_port) == p);
      hits_d[p]   = hits_q[p];
      misses_d[p] = misses_q[p];
      if (hit_inc[p]  && (hits_q[p]   != '1)) hits_d[p]   = hits_q[p]   + CNT_WIDTH'(1);
      if (miss_inc[p] && (misses_q[p] != '1)) misses_d[p] = misses_q[p] + CNT_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (sel) begin
          hold_rw_d   = reg_rd_wr_L_in;
          hold_addr_d = reg_addr_in;
          hold_data_d = reg_data_in;
          hold_src_d  = reg_src_in;
          out_req_d   = 1'b1;
          out_ack_d   = 1'b1;
          out_rw_d    = reg_rd_wr_L_in;
          out_addr_d  = reg_addr_in;
          out_src_d   = reg_src_in;
          if (reg_rd_wr_L_in) begin
            out_data_d = rd_val;
`ifdef OP_LUT_CLR_ON_READ_EN
            for (int p = 0; p < NUM_SRC_PORTS; p++) begin
              if (offi == 32'(6 + 2*p)) hits_d[p]   = CNT_WIDTH'(hit_inc[p]);
              if (offi == 32'(7 + 2*p)) misses_d[p] = CNT_WIDTH'(miss_inc[p]);
            end
`endif
          end else begin
            out_data_d = reg_data_in;
            state_d    = S_DONE;
            case (offi)
              32'd0: begin
                protect_d     = reg_data_in[31];
                oq_d          = reg_data_in[16 +: NQ];
                mac_d[47:32]  = reg_data_in[15:0];
              end
              32'd1: mac_d[31:0] = reg_data_in[31:0];
              32'd2: begin
                wr_addr_d = reg_data_in[LUT_DEPTH_BITS-1:0];
                wr_req_d  = 1'b1;
                tmo_d     = '0;
                state_d   = S_LUT_WR;
              end
              32'd3: begin
                rd_addr_d = reg_data_in[LUT_DEPTH_BITS-1:0];
                rd_req_d  = 1'b1;
                tmo_d     = '0;
                state_d   = S_LUT_RD;
              end
              32'd4: begin
                flush_idx_d = '0;
                wr_req_d    = 1'b1;
                tmo_d       = '0;
                state_d     = S_FLUSH_REQ;
              end
              default: begin
                // a ring write overrides any same-cycle increment
                for (int p = 0; p < NUM_SRC_PORTS; p++) begin
                  if (offi == 32'(6 + 2*p)) hits_d[p]   = reg_data_in[CNT_WIDTH-1:0];
                  if (offi == 32'(7 + 2*p)) misses_d[p] = reg_data_in[CNT_WIDTH-1:0];
                end
              end
            endcase
            // LUT ops and flush answer later, from DONE
            if (state_d != S_DONE) begin
              out_req_d  = 1'b0;
              out_ack_d  = 1'b0;
              out_rw_d   = 1'b0;
              out_addr_d = '0;
              out_data_d = '0;
              out_src_d  = '0;
            end
          end
        end else begin
          out_req_d  = reg_req_in;
          out_ack_d  = reg_ack_in;
          out_rw_d   = reg_rd_wr_L_in;
          out_addr_d = reg_addr_in;
          out_data_d = reg_data_in;
          out_src_d  = reg_src_in;
        end
      end
      S_LUT_WR: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          fin      = 1'b1;
        end else if (tmo_end) begin
          wr_req_d = 1'b0;
          tmo_fail = 1'b1;
        end else tmo_d = tmo_q + TMO_W'(1);
      end
      S_LUT_RD: begin
        if (rd_ack) begin
          rd_req_d  = 1'b0;
          protect_d = rd_wr_protect;
          oq_d      = rd_oq;
          mac_d     = rd_mac;
          fin       = 1'b1;
        end else if (tmo_end) begin
          rd_req_d = 1'b0;
          tmo_fail = 1'b1;
        end else tmo_d = tmo_q + TMO_W'(1);
      end
      S_FLUSH_REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          tmo_d    = '0;
          state_d  = S_FLUSH_REL;
        end else if (tmo_end) begin
          wr_req_d = 1'b0;
          tmo_fail = 1'b1;
        end else tmo_d = tmo_q + TMO_W'(1);
      end
      S_FLUSH_REL: begin
        if (!wr_ack) begin
          if (flush_idx_q == '1) fin = 1'b1;
          else begin
            flush_idx_d = flush_idx_q + LUT_DEPTH_BITS'(1);
            wr_req_d    = 1'b1;
            tmo_d       = '0;
            state_d     = S_FLUSH_REQ;
          end
        end else if (tmo_end) tmo_fail = 1'b1;
        else tmo_d = tmo_q + TMO_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (tmo_fail) begin
      fin      = 1'b1;
      fin_data = BAD;
      if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
    end
    if (fin) begin
      state_d    = S_DONE;
      out_req_d  = 1'b1;
      out_ack_d  = 1'b1;
      out_rw_d   = hold_rw_q;
      out_addr_d = hold_addr_q;
      out_src_d  = hold_src_q;
      out_data_d = fin_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      out_req_q     <= 1'b0;
      out_ack_q     <= 1'b0;
      out_rw_q      <= 1'b0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
      out_src_q     <= '0;
      hold_rw_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      hold_src_q    <= '0;
      protect_q     <= 1'b0;
      oq_q          <= '0;
      mac_q         <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      flush_idx_q   <= '0;
      tmo_q         <= '0;
      timeout_cnt_q <= '0;
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      for (int p = 0; p < NUM_SRC_PORTS; p++) begin
        hits_q[p]   <= '0;
        misses_q[p] <= '0;
      end
    end else begin
      state_q       <= state_d;
      out_req_q     <= out_req_d;
      out_ack_q     <= out_ack_d;
      out_rw_q      <= out_rw_d;
      out_addr_q    <= out_addr_d;
      out_data_q    <= out_data_d;
      out_src_q     <= out_src_d;
      hold_rw_q     <= hold_rw_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      hold_src_q    <= hold_src_d;
      protect_q     <= protect_d;
      oq_q          <= oq_d;
      mac_q         <= mac_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      flush_idx_q   <= flush_idx_d;
      tmo_q         <= tmo_d;
      timeout_cnt_q <= timeout_cnt_d;
      rd_req_q      <= rd_req_d;
      wr_req_q      <= wr_req_d;
      for (int p = 0; p < NUM_SRC_PORTS; p++) begin
        hits_q[p]   <= hits_d[p];
        misses_q[p] <= misses_d[p];
      end
    end
  end

  assign reg_req_out     = out_req_q;
  assign reg_ack_out     = out_ack_q;
  assign reg_rd_wr_L_out = out_rw_q;
  assign reg_addr_out    = out_addr_q;
  assign reg_data_out    = out_data_q;
  assign reg_src_out     = out_src_q;
  assign rd_addr         = rd_addr_q;
  assign rd_req          = rd_req_q;
  assign wr_req          = wr_req_q;
  // a flush drives the write port with an all-zero entry
  assign wr_addr         = flushing ? flush_idx_q : wr_addr_q;
  assign wr_oq           = flushing ? '0 : oq_q;
  assign wr_protect      = !flushing && protect_q;
  assign wr_mac          = flushing ? '0 : mac_q;

endmodule

// File: tb/tb_op_lut_regs_mc.sv
// Scoreboard bench for op_lut_regs_mc: LUT responder model, ring stimulus, monitor-side comparison.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_op_lut_regs_mc;
  localparam int AW = `UDP_REG_ADDR_WIDTH;
  localparam int NSP = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0, reset_n = 1'b0;
  logic reg_req_in = 0, reg_ack_in = 0, reg_rd_wr_L_in = 0;
  logic [AW-1:0] reg_addr_in = '0;
  logic [31:0] reg_data_in = '0;
  logic [1:0] reg_src_in = '0;
  logic reg_req_out, reg_ack_out, reg_rd_wr_L_out;
  logic [AW-1:0] reg_addr_out;
  logic [31:0] reg_data_out;
  logic [1:0] reg_src_out;
  logic [4:0] rd_addr, wr_addr;
  logic rd_req, wr_req, wr_protect;
  logic [7:0] rd_oq = '0, wr_oq;
  logic rd_wr_protect = 0, rd_ack = 0, wr_ack = 0;
  logic [47:0] rd_mac = '0, wr_mac;
  logic lut_hit = 0, lut_miss = 0;
  logic [1:0] lut_src_port = '0;

  op_lut_regs_mc #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .reg_req_in(reg_req_in), .reg_ack_in(reg_ack_in), .reg_rd_wr_L_in(reg_rd_wr_L_in),
    .reg_addr_in(reg_addr_in), .reg_data_in(reg_data_in), .reg_src_in(reg_src_in),
    .reg_req_out(reg_req_out), .reg_ack_out(reg_ack_out), .reg_rd_wr_L_out(reg_rd_wr_L_out),
    .reg_addr_out(reg_addr_out), .reg_data_out(reg_data_out), .reg_src_out(reg_src_out),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_oq(rd_oq), .rd_wr_protect(rd_wr_protect),
    .rd_mac(rd_mac), .rd_ack(rd_ack),
    .wr_addr(wr_addr), .wr_req(wr_req), .wr_oq(wr_oq), .wr_protect(wr_protect),
    .wr_mac(wr_mac), .wr_ack(wr_ack),
    .lut_hit(lut_hit), .lut_miss(lut_miss), .lut_src_port(lut_src_port)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rw; logic [AW-1:0] addr; logic [1:0] src; logic [31:0] data; logic ack; int cyc;
  } rsp_t;
  rsp_t exp_q[$];
  int last_rsp_cyc = 0;

  // monitor: every ring output request must match the oldest expected response
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (reg_req_out) begin
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_rsp", reg_req_out, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_rw", reg_rd_wr_L_out, e.rw);
        chk("rsp_addr", reg_addr_out, e.addr);
        chk("rsp_src", reg_src_out, e.src);
        chk("rsp_data", reg_data_out, e.data);
        chk("rsp_ack", reg_ack_out, e.ack);
        if (e.cyc >= 0) chk("rsp_latency", cyc, e.cyc);
      end
    end
  end

  // LUT model: table contents plus a log of every write the DUT issues
  logic [47:0] m_mac[32];
  logic [7:0]  m_oq[32];
  logic        m_prot[32];
  typedef struct { logic [4:0] a; logic [47:0] mac; logic [7:0] oq; logic p; } wlog_t;
  wlog_t wlog[$];
  int wr_dly = 0, rd_dly = 0, wr_req_cyc = 0, wr_ack_cyc = 0;
  bit wr_never = 0;

  initial begin
    int wc = 0, rc = 0;
    logic wr_prev = 0;
    wlog_t w;
    forever begin
      @(negedge clk);
      if (wr_req && !wr_prev) wr_req_cyc = cyc;
      wr_prev = wr_req;
      if (!wr_req) begin wr_ack = 0; wc = 0; end
      else if (!wr_ack && !wr_never) begin
        if (wc >= wr_dly) begin
          wr_ack = 1; wr_ack_cyc = cyc;
          w.a = wr_addr; w.mac = wr_mac; w.oq = wr_oq; w.p = wr_protect;
          wlog.push_back(w);
          m_mac[wr_addr] = wr_mac; m_oq[wr_addr] = wr_oq; m_prot[wr_addr] = wr_protect;
        end else wc++;
      end
      if (!rd_req) begin rd_ack = 0; rc = 0; end
      else if (!rd_ack) begin
        if (rc >= rd_dly) begin
          rd_ack = 1;
          rd_mac = m_mac[rd_addr]; rd_oq = m_oq[rd_addr]; rd_wr_protect = m_prot[rd_addr];
        end else rc++;
      end
    end
  end

  int m_hits[NSP], m_miss[NSP];
  function automatic void m_inc(input int port, input logic h, input logic m);
    if (port < NSP) begin
      if (h && m_hits[port] < CMAX) m_hits[port]++;
      if (m && m_miss[port] < CMAX) m_miss[port]++;
    end
  endfunction

  function automatic logic [AW-1:0] badr(input int off);
    return AW'(off);
  endfunction

  task automatic wait_rsp();
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      chk("rsp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic ring(input logic rw, input logic [AW-1:0] addr, input logic [31:0] d,
                      input logic [31:0] expd, input logic expack, input int lat,
                      input logic h, input logic m, input logic [1:0] port);
    rsp_t e;
    logic blk;
    blk = (addr[AW-1:6] == '0);
    @(posedge clk); #1;
    reg_req_in = 1; reg_rd_wr_L_in = rw; reg_addr_in = addr; reg_data_in = d;
    reg_src_in = 2'($urandom); reg_ack_in = blk ? 1'b0 : expack;
    lut_hit = h; lut_miss = m; lut_src_port = port;
    e.rw = rw; e.addr = addr; e.src = reg_src_in; e.data = expd;
    e.ack = blk ? 1'b1 : expack; e.cyc = (lat < 0) ? -1 : cyc + lat;
    exp_q.push_back(e);
    @(posedge clk); #1;
    reg_req_in = 0; reg_ack_in = 0; lut_hit = 0; lut_miss = 0;
    wait_rsp();
  endtask

  task automatic wr(input int off, input logic [31:0] d, input int lat);
    ring(1'b0, badr(off), d, d, 1'b1, lat, 1'b0, 1'b0, 2'd0);
  endtask
  task automatic rd(input int off, input logic [31:0] expd);
    ring(1'b1, badr(off), $urandom, expd, 1'b1, 1, 1'b0, 1'b0, 2'd0);
  endtask
  task automatic rd_cnt(input int port, input bit miss);
    rd(6 + 2*port + int'(miss), miss ? m_miss[port] : m_hits[port]);
`ifdef OP_LUT_CLR_ON_READ_EN
    if (miss) m_miss[port] = 0; else m_hits[port] = 0;
`endif
  endtask
  task automatic lut_pulse(input int port, input logic h, input logic m);
    @(posedge clk); #1;
    lut_hit = h; lut_miss = m; lut_src_port = 2'(port);
    @(posedge clk); #1;
    lut_hit = 0; lut_miss = 0;
    m_inc(port, h, m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] mac;
    logic [7:0] oq;
    logic p;
    int a, b, bad;
    for (int i = 0; i < 32; i++) begin
      m_mac[i] = {16'($urandom), 32'($urandom)}; m_oq[i] = 8'($urandom); m_prot[i] = 1'($urandom);
    end
    for (int i = 0; i < NSP; i++) begin m_hits[i] = 0; m_miss[i] = 0; end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_out", reg_req_out, 0);
    chk("reset_ack_out", reg_ack_out, 0);
    chk("reset_data_out", reg_data_out, 0);
    chk("reset_wr_req", wr_req, 0);
    chk("reset_rd_req", rd_req, 0);
    reset_n = 1;
    rd(5, 32'h0);
    rd(0, 32'h0);

    // directed LUT write
    wr(0, 32'h8003_1234, 1);
    wr(1, 32'h5678_9ABC, 1);
    wlog.delete(); wr_dly = 3;
    wr(2, 7, -1);
    chk("lut_wr_count", wlog.size(), 1);
    if (wlog.size() > 0)
      chk("lut_wr_entry", {wlog[0].a, wlog[0].mac, wlog[0].oq, wlog[0].p},
          {5'd7, 48'h1234_5678_9ABC, 8'h03, 1'b1});
    chk("wr_ack_to_rsp", last_rsp_cyc - wr_ack_cyc, 1);

    // directed LUT read
    m_mac[4] = 48'hAABB_CCDD_EEFF; m_oq[4] = 8'h05; m_prot[4] = 0; rd_dly = 2;
    wr(3, 4, -1);
    rd(0, 32'h0005_AABB);
    rd(1, 32'hCCDD_EEFF);
    rd(3, 4);

    // random write/read round trips
    for (int it = 0; it < 6; it++) begin
      a = int'($urandom % 32); mac = {16'($urandom), 32'($urandom)}; oq = 8'($urandom); p = 1'($urandom);
      wr(0, {p, 7'b0, oq, mac[47:32]}, 1);
      wr(1, mac[31:0], 1);
      wlog.delete(); wr_dly = int'($urandom % 4);
      wr(2, 32'(a), -1);
      if (wlog.size() > 0) chk("rand_wr_entry", {wlog[0].a, wlog[0].mac, wlog[0].oq, wlog[0].p},
                               {5'(a), mac, oq, p});
      else chk("rand_wr_count", wlog.size(), 1);
      rd(2, 32'(a));
      b = int'($urandom % 32); rd_dly = int'($urandom % 4);
      wr(3, 32'(b), -1);
      rd(0, {m_prot[b], 7'b0, m_oq[b], m_mac[b][47:32]});
      rd(1, m_mac[b][31:0]);
    end

    // flush
    wlog.delete(); wr_dly = 0;
    wr(4, 32'h0000_00A5, -1);
    chk("flush_count", wlog.size(), 32);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].a != 5'(i) || wlog[i].mac != 0 || wlog[i].oq != 0 || wlog[i].p != 0) bad++;
    chk("flush_entries_bad", bad, 0);
    b = int'($urandom % 32);
    wr(3, 32'(b), -1);
    rd(0, 32'h0);
    rd(5, 32'h0);

    // ack timeout
    wr_never = 1;
    ring(1'b0, badr(2), 32'd9, 32'hDEAD_BEEF, 1'b1, -1, 1'b0, 1'b0, 2'd0);
    chk("timeout_latency", last_rsp_cyc - wr_req_cyc, 64);
    wr_never = 0;
    rd(5, 32'h0000_0100);
    wr(5, 32'h0000_FFFF, 1);
    rd(5, 32'h0000_0100);

    // counters
    for (int i = 0; i < 2*NSP; i++) wr(6 + i, 0, 1);
    for (int i = 0; i < 150; i++) lut_pulse(int'($urandom % 4), 1'($urandom), 1'($urandom));
    for (int i = 0; i < NSP; i++) begin rd_cnt(i, 0); rd_cnt(i, 1); end
    wr(10, 0, 1); m_hits[2] = 0;
    for (int i = 0; i < 20; i++) lut_pulse(2, 1, 0);
    rd(10, 32'h0000_000F); m_hits[2] = 15;
    wr(8, 0, 1); wr(9, 0, 1); m_hits[1] = 0; m_miss[1] = 0;
    lut_pulse(1, 1, 1);
    rd_cnt(1, 0); rd_cnt(1, 1);
    wr(8, 3, 1); m_hits[1] = 3;
    ring(1'b1, badr(8), 0, 32'(m_hits[1]), 1'b1, 1, 1'b1, 1'b0, 2'd1);
`ifdef OP_LUT_CLR_ON_READ_EN
    m_hits[1] = 1;
`else
    m_inc(1, 1, 0);
`endif
    rd_cnt(1, 0);
    ring(1'b0, badr(6), 5, 5, 1'b1, 1, 1'b1, 1'b0, 2'd0);
    m_hits[0] = 5;
    rd_cnt(0, 0);
    rd(30, 32'hDEAD_BEEF);
    wr(20, 32'h1, 1);

    // pass-through of requests for other blocks
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] ad;
      logic [31:0] d;
      ad = AW'($urandom);
      if (ad[AW-1:6] == '0) ad[AW-1] = 1'b1;
      d = $urandom;
      ring(1'($urandom), ad, d, d, 1'($urandom), 1, 1'b0, 1'b0, 2'd0);
    end

    // reset in the middle of a flush
    wr_dly = 1;
    @(posedge clk); #1;
    reg_req_in = 1; reg_rd_wr_L_in = 0; reg_addr_in = badr(4); reg_data_in = 0;
    @(posedge clk); #1;
    reg_req_in = 0;
    repeat (10) @(posedge clk);
    #1 reset_n = 0;
    @(posedge clk); #1;
    chk("rst_flush_wr_req", wr_req, 0);
    chk("rst_flush_req_out", reg_req_out, 0);
    reset_n = 1;
    for (int i = 0; i < NSP; i++) begin m_hits[i] = 0; m_miss[i] = 0; end
    rd(5, 32'h0);
    rd_cnt(2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
